fetch_queue: RTL and testbench



---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue_fifo.sv | 49 ++++
 rtl/fetch_queue.sv | 75 +++++++
 tb/tb_fetch_queue.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Package fetch_pkg: word widths, PC increment, NOP encoding, queue entry type.
package fetch_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: imem address/data, redirect, IF/ID valid/ready, occupancy.
// master = fetch queue side, slave = memory / pipeline side.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]        imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_pc4;
    logic [INSTR_W-1:0] out_instr;
    logic [CW-1:0]      q_count;

    modport master (
        output imem_addr, out_valid, out_pc4, out_instr, q_count,
        input  imem_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_pc4, out_instr, q_count,
        output imem_data, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count.
// Ports: clk, rst_n (sync, active-low), push/pop/flush, wdata in; head, count out.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage needs no reset: an empty queue masks the head to a NOP.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        head = '{pc4: '0, instr: NOP_INSTR};
        if (count != '0) head = mem[rd_ptr];
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC register, +4 fetch, entry queue and IF/ID valid/ready output.
// Ports: clk, rst_n (sync, active-low), bus (fetch_queue_if.master). Macro: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst_n,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [31:0]   pc4;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  out_e;
    logic          empty;
    logic          byp;
    logic          pop;
    logic          push;
    logic          fifo_push;
    logic          fifo_pop;

    assign pc4   = pc + PC_INC;
    assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = empty && !bus.redirect_valid;
`else
    assign byp = 1'b0;
`endif

    assign out_e = byp ? '{pc4: pc4, instr: bus.imem_data} : head;
    assign pop   = bus.out_valid && bus.out_ready;
    assign push  = !bus.redirect_valid && ((count < CW'(DEPTH)) || pop);

    // A bypassed entry goes straight to IF/ID and never enters storage.
    assign fifo_push = push && !(byp && bus.out_ready);
    assign fifo_pop  = pop && !empty;

    fetch_fifo #(
        .DEPTH(DEPTH),
        .CW   (CW)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (fifo_push),
        .pop  (fifo_pop),
        .flush(bus.redirect_valid),
        .wdata('{pc4: pc4, instr: bus.imem_data}),
        .head (head),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= bus.redirect_pc & ~32'h3;
        end else if (push) begin
            pc <= pc4;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.out_valid = !empty || byp;
    assign bus.out_pc4   = out_e.pc4;
    assign bus.out_instr = out_e.instr;
    assign bus.q_count   = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
// Directed scenarios from the test plan plus randomized ready/redirect/reset.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit          BYP      = 1'b1;
`else
    localparam bit          BYP      = 1'b0;
`endif

    logic clk;
    logic rst_n;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign bus.imem_data = memf(bus.imem_addr);

    // Reference model: PC plus a plain queue of {pc4, instr}.
    logic [31:0] mpc;
    logic [63:0] mq [$];

    int n_cmp;
    int n_bad;

    logic        o_valid;
    logic [31:0] o_addr;
    logic [31:0] o_pc4;
    logic [31:0] o_instr;
    logic [2:0]  o_cnt;
    logic [99:0] obs;
    logic [99:0] exp_v;

    task automatic mdl_expect();
        logic [31:0] p4;
        logic [31:0] ins;
        logic        v;
        v   = 1'b0;
        p4  = '0;
        ins = '0;
        if (mq.size() != 0) begin
            v   = 1'b1;
            p4  = mq[0][63:32];
            ins = mq[0][31:0];
        end else if (BYP && !bus.redirect_valid) begin
            v   = 1'b1;
            p4  = mpc + 32'd4;
            ins = memf(mpc);
        end
        exp_v = {v, mpc, p4, ins, 3'(mq.size())};
    endtask

    task automatic mdl_advance();
        bit empty;
        bit byp;
        bit pop;
        bit room;
        empty = (mq.size() == 0);
        byp   = BYP && empty && !bus.redirect_valid;
        pop   = (!empty || byp) && bus.out_ready;
        if (!rst_n) begin
            mpc = RST_PC;
            mq.delete();
        end else if (bus.redirect_valid) begin
            mq.delete();
            mpc = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            room = (mq.size() < DEPTH) || pop;
            if (pop && !empty) void'(mq.pop_front());
            if (room) begin
                if (!(byp && pop)) mq.push_back({mpc + 32'd4, memf(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    // Capture DUT and model at the falling edge, then advance across posedge.
    task automatic tick(input bit r, input bit rd, input logic [31:0] rp,
                        input bit rdy);
        rst_n              = r;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rp;
        bus.out_ready      = rdy;
        @(negedge clk);
        o_valid = bus.out_valid;
        o_addr  = bus.imem_addr;
        o_pc4   = bus.out_pc4;
        o_instr = bus.out_instr;
        o_cnt   = bus.q_count;
        obs     = {o_valid, o_addr, o_pc4, o_instr, o_cnt};
        mdl_expect();
        @(posedge clk);
        mdl_advance();
        #1;
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs !== {1'b0, RST_PC, 32'h0, 32'h0, 3'd0}) begin
            n_bad++;
            $display("FAIL reset got %h want %h", obs,
                     {1'b0, RST_PC, 32'h0, 32'h0, 3'd0});
        end
    endtask

    task automatic test_bypass();
        do_reset();
        tick(1, 0, 0, 1);
        n_cmp++;
        if ({o_valid, o_pc4, o_cnt} !== {BYP, BYP ? RST_PC + 32'd4 : 32'h0, 3'd0}) begin
            n_bad++;
            $display("FAIL bypass got v=%b pc4=%h cnt=%0d want v=%b", o_valid,
                     o_pc4, o_cnt, BYP);
        end
        n_cmp++;
        if (o_instr !== (BYP ? memf(RST_PC) : 32'h0)) begin
            n_bad++;
            $display("FAIL bypass_instr got %h want %h", o_instr,
                     BYP ? memf(RST_PC) : 32'h0);
        end
    endtask

    task automatic test_stall_fill();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, 0, 0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL stall c%0d got %h want %h", i, obs, exp_v);
            end
        end
        tick(1, 0, 0, 0);
        n_cmp++;
        if ({o_cnt, o_addr, o_pc4, o_instr} !== {3'd4, 32'h10, 32'h4, memf(0)}) begin
            n_bad++;
            $display("FAIL stall_full got cnt=%0d addr=%h pc4=%h ins=%h want 4/10/4/%h",
                     o_cnt, o_addr, o_pc4, o_instr, memf(0));
        end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        want = 32'h4;
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 1);
            n_cmp++;
            if ({o_valid, o_pc4, o_cnt} !== {1'b1, want, 3'd4} || obs !== exp_v) begin
                n_bad++;
                $display("FAIL stream c%0d got %h want pc4=%h cnt=4 (%h)", i, obs,
                         want, exp_v);
            end
            want = want + 32'd4;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        tick(1, 1, 32'h103, 1);
        n_cmp++;
        if (o_cnt !== 3'd3 || obs !== exp_v) begin
            n_bad++;
            $display("FAIL redir_pre got %h want %h", obs, exp_v);
        end
        tick(1, 0, 0, 0);
        n_cmp++;
        if (o_cnt !== 3'd0 || o_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL redir_flush got cnt=%0d addr=%h want 0/100", o_cnt, o_addr);
        end
        tick(1, 0, 0, 0);
        n_cmp++;
        if ({o_valid, o_pc4, o_instr} !== {1'b1, 32'h104, memf(32'h100)}) begin
            n_bad++;
            $display("FAIL redir_head got v=%b pc4=%h ins=%h want 1/104/%h",
                     o_valid, o_pc4, o_instr, memf(32'h100));
        end
    endtask

    task automatic test_wrap();
        tick(1, 1, 32'hFFFF_FFFC, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 1);
        n_cmp++;
        if ({o_pc4, o_cnt, o_addr} !== {32'h0, 3'd2, 32'h4}) begin
            n_bad++;
            $display("FAIL wrap_first got pc4=%h cnt=%0d addr=%h want 0/2/4",
                     o_pc4, o_cnt, o_addr);
        end
        tick(1, 0, 0, 0);
        n_cmp++;
        if ({o_pc4, o_instr} !== {32'h4, memf(32'h0)}) begin
            n_bad++;
            $display("FAIL wrap_second got pc4=%h ins=%h want 4/%h", o_pc4,
                     o_instr, memf(32'h0));
        end
    endtask

    task automatic test_reset_redirect();
        do_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 32'h200, 1);
        n_cmp++;
        if (o_cnt !== 3'd2) begin
            n_bad++;
            $display("FAIL rr_pre got cnt=%0d want 2", o_cnt);
        end
        tick(1, 1, 32'h300, 0);
        n_cmp++;
        if (obs !== {1'b0, RST_PC, 32'h0, 32'h0, 3'd0} || obs !== exp_v) begin
            n_bad++;
            $display("FAIL rr_state got %h want %h", obs,
                     {1'b0, RST_PC, 32'h0, 32'h0, 3'd0});
        end
    endtask

    task automatic test_random();
        bit r;
        bit rd;
        bit rdy;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) != 0);
            rd  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tick(r, rd, $urandom, rdy);
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL random c%0d got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        n_cmp              = 0;
        n_bad              = 0;
        mpc                = RST_PC;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_bypass();
        test_stall_fill();
        test_stream();
        test_redirect();
        test_wrap();
        test_reset_redirect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
